// File: rtl/intr_seq_ctrl_if.sv
// Bus between the interrupt sequencer and its environment (resolver, CPU, command port).
interface intr_seq_ctrl_if;
    logic       isprior;
    logic [2:0] req_lvl;
    logic       inta;
    logic       ocw_wr;
    logic [7:0] ocw2;
    logic [4:0] vbase;
    logic       aeoi;
    logic       int_o;
    logic [7:0] isr;
    logic [2:0] lp;
    logic [7:0] irr_clr;
    logic [7:0] vec;
    logic       vec_vld;

    modport master (
        output isprior, req_lvl, inta, ocw_wr, ocw2, vbase, aeoi,
        input  int_o, isr, lp, irr_clr, vec, vec_vld
    );
    modport slave (
        input  isprior, req_lvl, inta, ocw_wr, ocw2, vbase, aeoi,
        output int_o, isr, lp, irr_clr, vec, vec_vld
    );
endinterface

// File: rtl/intr_seq_ctrl.sv
// Interrupt acknowledge sequencer: drives INT, runs the two-pulse INTA cycle,
// owns the in-service register, the rotating priority pointer and EOI commands.
module intr_seq_ctrl #(
    parameter int INTA_TO = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    intr_seq_ctrl_if.slave  bus
);
    localparam int CW = $clog2(INTA_TO + 1);

    typedef enum logic [1:0] {IDLE, PEND, ACK1, ACK2} state_e;

    state_e          state_q, state_d;
    logic            inta_q;
    logic [2:0]      lvl_q, lvl_d;
    logic            spur_q, spur_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      isr_q, isr_d;
    logic [7:0]      irr_clr_q;
    logic [2:0]      lp_q, lp_d;
    logic            rot_q, rot_d;

    logic            rise, fall;
    logic [7:0]      set_mask, fsm_clr, cmd_clr;
    logic            aeoi_rot, cmd_lp_vld;
    logic [2:0]      cmd_lp, hi_lvl, idx;
    logic            hi_vld;
    logic            unused_ocw;

    assign rise       = bus.inta & ~inta_q;
    assign fall       = ~bus.inta & inta_q;
    assign unused_ocw = ^bus.ocw2[4:3];

    // Walk from lowest to highest priority so the last hit is the highest one.
    always_comb begin
        hi_lvl = '0;
        hi_vld = 1'b0;
        idx    = '0;
        for (int k = 8; k >= 1; k--) begin
            idx = lp_q + 3'(k);
            if (isr_q[idx]) begin
                hi_lvl = idx;
                hi_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        spur_d   = spur_q;
        cnt_d    = '0;
        set_mask = '0;
        fsm_clr  = '0;
        aeoi_rot = 1'b0;
        case (state_q)
            IDLE: if (bus.isprior) state_d = PEND;
            PEND: if (rise) begin
                state_d = ACK1;
                if (bus.isprior) begin
                    lvl_d    = bus.req_lvl;
                    spur_d   = 1'b0;
                    set_mask = 8'b1 << bus.req_lvl;
                end else begin
                    lvl_d  = 3'd7;
                    spur_d = 1'b1;
                end
            end
            ACK1: begin
                if (rise) begin
                    state_d = ACK2;
                end else if (cnt_q == CW'(INTA_TO)) begin
                    state_d = IDLE;
                    if (!spur_q) fsm_clr = 8'b1 << lvl_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK2: if (fall) begin
                state_d = IDLE;
                if (bus.aeoi && !spur_q) begin
                    fsm_clr  = 8'b1 << lvl_q;
                    aeoi_rot = rot_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_clr    = '0;
        cmd_lp_vld = 1'b0;
        cmd_lp     = '0;
        rot_d      = rot_q;
        if (bus.ocw_wr) begin
            case (bus.ocw2[7:5])
                3'b001: if (hi_vld) cmd_clr = 8'b1 << hi_lvl;
                3'b011: cmd_clr = 8'b1 << bus.ocw2[2:0];
                3'b101: if (hi_vld) begin
                    cmd_clr    = 8'b1 << hi_lvl;
                    cmd_lp_vld = 1'b1;
                    cmd_lp     = hi_lvl;
                end
                3'b111: begin
                    cmd_clr    = 8'b1 << bus.ocw2[2:0];
                    cmd_lp_vld = 1'b1;
                    cmd_lp     = bus.ocw2[2:0];
                end
                3'b100: rot_d = 1'b1;
                3'b000: rot_d = 1'b0;
                3'b110: begin
                    cmd_lp_vld = 1'b1;
                    cmd_lp     = bus.ocw2[2:0];
                end
                default: ;
            endcase
        end
    end

    // Clears act on the pre-set value; a same-cycle set on the same bit survives.
    assign isr_d = (isr_q & ~fsm_clr & ~cmd_clr) | set_mask;
    assign lp_d  = cmd_lp_vld ? cmd_lp : (aeoi_rot ? lvl_q : lp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            inta_q    <= 1'b0;
            lvl_q     <= '0;
            spur_q    <= 1'b0;
            cnt_q     <= '0;
            isr_q     <= '0;
            irr_clr_q <= '0;
            lp_q      <= 3'd7;
            rot_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inta_q    <= bus.inta;
            lvl_q     <= lvl_d;
            spur_q    <= spur_d;
            cnt_q     <= cnt_d;
            isr_q     <= isr_d;
            irr_clr_q <= set_mask;
            lp_q      <= lp_d;
            rot_q     <= rot_d;
        end
    end

    assign bus.int_o   = (state_q == PEND);
    assign bus.vec_vld = (state_q == ACK2);
    assign bus.vec     = bus.vec_vld ? {bus.vbase, lvl_q} : 8'h00;
    assign bus.isr     = isr_q;
    assign bus.lp      = lp_q;
    assign bus.irr_clr = irr_clr_q;
endmodule

// File: tb/tb_intr_seq_ctrl.sv
// Directed + randomized bench for intr_seq_ctrl against a transaction-level model.
module tb_intr_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: whole-transaction view of ISR, priority pointer and rotate flag.
    bit [7:0] m_isr;
    int       m_lp;
    bit       m_rot;

    intr_seq_ctrl_if bus();
    intr_seq_ctrl #(.INTA_TO(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int m_hi();
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (m_lp + k) % 8;
            if (m_isr[i]) return i;
        end
        return -1;
    endfunction

    function automatic void m_ocw(input logic [7:0] c);
        int h;
        int l;
        h = m_hi();
        l = int'(c[2:0]);
        case (c[7:5])
            3'b001: if (h >= 0) m_isr[h] = 1'b0;
            3'b011: m_isr[l] = 1'b0;
            3'b101: if (h >= 0) begin m_isr[h] = 1'b0; m_lp = h; end
            3'b111: begin m_isr[l] = 1'b0; m_lp = l; end
            3'b100: m_rot = 1'b1;
            3'b000: m_rot = 1'b0;
            3'b110: m_lp = l;
            default: ;
        endcase
    endfunction

    task automatic do_ocw(input logic [7:0] c);
        bus.ocw2   = c;
        bus.ocw_wr = 1'b1;
        tick();
        bus.ocw_wr = 1'b0;
        m_ocw(c);
        tick();
        chk("ocw_isr", bus.isr, m_isr);
        chk("ocw_lp", {5'b0, bus.lp}, 8'(m_lp));
    endtask

    // One INTA acknowledge: spur drops isprior before the first pulse, tmo withholds
    // the second pulse, hold stops while the vector is on the bus.
    task automatic do_ack(input logic [2:0] l, input bit spur, input bit tmo, input bit hold);
        logic [2:0] vl;
        bit         seen;
        vl   = spur ? 3'd7 : l;
        seen = 1'b0;
        chk("idle_int", {7'b0, bus.int_o}, 8'h00);
        bus.isprior = 1'b1;
        bus.req_lvl = l;
        tick();
        chk("pend_int", {7'b0, bus.int_o}, 8'h01);
        chk("pend_vec", bus.vec, 8'h00);
        if (spur) bus.isprior = 1'b0;
        bus.inta = 1'b1;
        tick();
        bus.isprior = 1'b0;
        if (!spur) m_isr[l] = 1'b1;
        chk("ack1_int", {7'b0, bus.int_o}, 8'h00);
        chk("ack1_irr", bus.irr_clr, spur ? 8'h00 : (8'h01 << l));
        chk("ack1_isr", bus.isr, m_isr);
        tick();
        chk("irr_pulse", bus.irr_clr, 8'h00);
        bus.inta = 1'b0;
        tick();
        if (tmo) begin
            for (int i = 0; i < 22; i++) begin
                tick();
                if (bus.vec_vld) seen = 1'b1;
            end
            if (!spur) m_isr[l] = 1'b0;
            chk("tmo_vld", {7'b0, seen}, 8'h00);
            chk("tmo_isr", bus.isr, m_isr);
            return;
        end
        bus.inta = 1'b1;
        tick();
        chk("ack2_vld", {7'b0, bus.vec_vld}, 8'h01);
        chk("ack2_vec", bus.vec, {bus.vbase, vl});
        if (hold) return;
        tick();
        bus.inta = 1'b0;
        tick();
        if (bus.aeoi && !spur) begin
            m_isr[l] = 1'b0;
            if (m_rot) m_lp = int'(l);
        end
        chk("exit_vld", {7'b0, bus.vec_vld}, 8'h00);
        chk("exit_vec", bus.vec, 8'h00);
        chk("exit_isr", bus.isr, m_isr);
        chk("exit_lp", {5'b0, bus.lp}, 8'(m_lp));
    endtask

    task automatic chk_reset_vals();
        chk("rst_int", {7'b0, bus.int_o}, 8'h00);
        chk("rst_isr", bus.isr, 8'h00);
        chk("rst_lp", {5'b0, bus.lp}, 8'h07);
        chk("rst_irr", bus.irr_clr, 8'h00);
        chk("rst_vec", bus.vec, 8'h00);
        chk("rst_vld", {7'b0, bus.vec_vld}, 8'h00);
    endtask

    initial begin
        logic [7:0] c;
        bus.isprior = 1'b0; bus.req_lvl = '0; bus.inta = 1'b0; bus.ocw_wr = 1'b0;
        bus.ocw2 = '0; bus.vbase = 5'b01000; bus.aeoi = 1'b0;
        m_isr = '0; m_lp = 7; m_rot = 1'b0;
        tick(); tick();
        chk_reset_vals();
        rst_n = 1'b1;

        // Basic level-3 acknowledge then level 5 to build isr=0x28
        do_ack(3'd3, 1'b0, 1'b0, 1'b0);
        chk("basic_isr", bus.isr, 8'h08);
        do_ack(3'd5, 1'b0, 1'b0, 1'b0);
        chk("isr_28", bus.isr, 8'h28);

        // EOI sequence
        do_ocw(8'h20);
        chk("eoi_ns", bus.isr, 8'h20);
        do_ocw(8'hE5);
        chk("eoi_rs_isr", bus.isr, 8'h00);
        chk("eoi_rs_lp", {5'b0, bus.lp}, 8'h05);
        do_ocw(8'h20);
        chk("eoi_empty_lp", {5'b0, bus.lp}, 8'h05);

        // AEOI with rotation
        do_ocw(8'hC7);
        do_ocw(8'h80);
        bus.aeoi = 1'b1;
        do_ack(3'd5, 1'b0, 1'b0, 1'b0);
        chk("aeoi_isr", bus.isr, 8'h00);
        chk("aeoi_lp", {5'b0, bus.lp}, 8'h05);
        bus.aeoi = 1'b0;

        // Spurious then timeout
        do_ack(3'd1, 1'b0, 1'b0, 1'b0);
        do_ack(3'd4, 1'b1, 1'b0, 1'b0);
        chk("spur_isr", bus.isr, 8'h02);
        do_ack(3'd2, 1'b0, 1'b1, 1'b0);
        chk("tmo_isr_lit", bus.isr, 8'h02);

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                c = {3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7))};
                do_ocw(c);
            end else begin
                bus.aeoi  = 1'($urandom_range(0, 1));
                bus.vbase = 5'($urandom);
                do_ack(3'($urandom_range(0, 7)), $urandom_range(0, 5) == 0,
                       $urandom_range(0, 7) == 0, 1'b0);
            end
        end

        // Reset mid-ACK2, then a fresh acknowledge
        bus.aeoi  = 1'b0;
        bus.vbase = 5'b01000;
        do_ack(3'd6, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        bus.inta = 1'b0;
        tick();
        rst_n = 1'b1;
        m_isr = '0; m_lp = 7; m_rot = 1'b0;
        do_ack(3'd6, 1'b0, 1'b0, 1'b0);
        chk("post_rst_isr", bus.isr, 8'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/intr_seq_ctrl.md
INTR_SEQ_CTRL -- requirements
Module: intr_seq_ctrl

Interface
REQ-001 Parameter INTA_TO, default 15: clock cycles allowed in ACK1 without a second INTA before abort.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 isprior  input  1  from priority resolver: an unmasked request outranks current in-service level.
REQ-005 req_lvl  input  3  from priority resolver: level (0-7) of that request, valid when isprior=1.
REQ-006 inta  input  1  CPU acknowledge level; two high pulses per acknowledge cycle.
REQ-007 ocw_wr  input  1  one-cycle strobe: ocw2 holds a valid command.
REQ-008 ocw2  input  8  command byte; [7]=R, [6]=SL, [5]=EOI, [2:0]=L; [4:3] ignored.
REQ-009 vbase  input  5  vector base T7..T3.
REQ-010 aeoi  input  1  auto-EOI mode enable.
REQ-011 int_o  output  1  interrupt request to CPU.
REQ-012 isr  output  8  in-service register, fed back to the resolver.
REQ-013 lp  output  3  lowest-priority level pointer, fed back to the resolver.
REQ-014 irr_clr  output  8  one-hot, one-cycle clear pulse to the request register.
REQ-015 vec  output  8  interrupt vector.
REQ-016 vec_vld  output  1  vec valid.

Function
REQ-017 Priority order is circular: highest = (lp+1) mod 8, lowest = lp.
REQ-018 inta is registered (inta_q); rise = inta & ~inta_q; fall = ~inta & inta_q.
REQ-019 FSM states: IDLE, PEND, ACK1, ACK2.
REQ-020 IDLE: isprior=1 -> PEND; int_o=1 from the next cycle.
REQ-021 PEND: int_o held 1 until rise, independent of isprior.
REQ-022 PEND, rise: -> ACK1; int_o=0 the next cycle; latch lvl=req_lvl if isprior=1, else lvl=7 with spurious flag set.
REQ-023 On the PEND->ACK1 transition, when not spurious: isr[lvl] set and irr_clr[lvl] pulsed, both visible for exactly one cycle starting the next cycle (irr_clr); isr bit persists.
REQ-024 Spurious acknowledge: no isr set, no irr_clr pulse, vector still issued for level 7.
REQ-025 ACK1: a cycle counter starts at 0; rise -> ACK2; counter reaching INTA_TO -> IDLE, clear isr[lvl] if set by this cycle, vec_vld stays 0.
REQ-026 ACK2: vec={vbase,lvl} and vec_vld=1 while in ACK2; fall -> IDLE, vec_vld=0 the next cycle.
REQ-027 ACK2 exit with aeoi=1: clear isr[lvl]; if rot_aeoi=1, lp<=lvl.
REQ-028 ocw_wr commands (R,SL,EOI), each applied in the cycle after the strobe:
  - 001: non-specific EOI -- clear the highest-priority set isr bit.
  - 011: specific EOI -- clear isr[L].
  - 101: rotate on non-specific EOI -- clear highest set bit n, lp<=n.
  - 111: rotate on specific EOI -- clear isr[L], lp<=L.
  - 100: rot_aeoi<=1.
  - 000: rot_aeoi<=0.
  - 110: set priority, lp<=L.
  - 010: no operation.
REQ-029 Non-specific or rotating EOI with isr=0: no isr change, no lp change.
REQ-030 Simultaneous EOI and ISR set: the EOI is evaluated on the pre-set isr value; the set is applied after; a set wins on the same bit.
REQ-031 Simultaneous auto-EOI clear and EOI command: both clears are applied; if both rotate, the command's lp value wins.
REQ-032 isprior is ignored in ACK1/ACK2; new requests are served only after return to IDLE.
REQ-033 vec=8'h00 whenever vec_vld=0.

Reset
REQ-034 rst_n=0 forces immediately, in any state (mid-acknowledge included): state=IDLE, int_o=0, isr=0, lp=7, irr_clr=0, vec=0, vec_vld=0, rot_aeoi=0, inta_q=0, counter=0.
REQ-035 The first isprior can be accepted on the first clock edge after rst_n deasserts.

Verification
REQ-036 Basic: vbase=5'b01000, isprior=1, req_lvl=3, two inta pulses -> int_o=1; irr_clr=8'h08 for one cycle; isr=8'h08; vec=8'h43 with vec_vld=1 during the second pulse.
REQ-037 AEOI with rotation: aeoi=1, ocw2=8'h80, level-5 acknowledge -> after the second inta falls, isr=0 and lp=5.
REQ-038 EOI: isr=8'h28 with lp=7, ocw2=8'h20 -> isr=8'h20; then ocw2=8'hE5 -> isr=0 and lp=5; then ocw2=8'h20 -> no change.
REQ-039 Spurious and timeout: isprior drops before the first inta -> vec=8'h47, isr unchanged. In a separate acknowledge, the second inta is withheld for more than 15 cycles -> IDLE, isr bit cleared, vec_vld never asserted.
REQ-040 Reset mid-ACK2 -> all outputs at reset values in the same cycle; a fresh acknowledge afterwards completes normally.
